// File: rtl/chip_id_shift_reader.sv
// Serial reader for the hard chip ID block; presents the 64-bit ID as a constant Avalon-ST source.
// Optional re-read request port enabled by defining CHIP_ID_RESCAN_EN.
module chip_id_shift_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        chipid_clk,
  output logic        chipid_shiftnld,
  input  logic        chipid_regout,
  output logic [63:0] aso_out0_data,
  output logic        aso_out0_valid,
`ifdef CHIP_ID_RESCAN_EN
  input  logic        rescan,
`endif
  input  logic        aso_out0_ready
);

  localparam int H  = CLK_DIV / 2;
  localparam int DW = (H > 1) ? $clog2(H) : 1;
  localparam logic [DW-1:0] H_LAST = DW'(H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          ck_q, ck_d;
  logic          snl_q, snl_d;
  logic          valid_q, valid_d;
  logic [63:0]   data_q, data_d;
  logic          rescan_req;
  logic          tick;
  logic          fall;

  // The ID never changes, so the sink's backpressure has nothing to act on.
  logic unused_ready;
  assign unused_ready = aso_out0_ready;

`ifdef CHIP_ID_RESCAN_EN
  assign rescan_req = rescan;
`else
  assign rescan_req = 1'b0;
`endif

  assign tick = (div_q == H_LAST);
  assign fall = tick && ck_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    ck_d    = ck_q;
    snl_d   = snl_q;
    valid_d = valid_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        snl_d   = 1'b0;
        div_d   = '0;
        cnt_d   = '0;
        ck_d    = 1'b0;
      end
      S_LOAD, S_SHIFT: begin
        if (tick) begin
          ck_d  = ~ck_q;
          div_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
        // Sample on the falling event: half a period after the block's rising-edge update.
        if (fall) begin
          data_d = {chipid_regout, data_q[63:1]};
          cnt_d  = cnt_q + 7'd1;
          snl_d  = 1'b1;
          if (state_q == S_LOAD) begin
            state_d = S_SHIFT;
          end else if (cnt_q == 7'd63) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            ck_d    = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (rescan_req) begin
          state_d = S_LOAD;
          valid_d = 1'b0;
          snl_d   = 1'b0;
          div_d   = '0;
          cnt_d   = '0;
          ck_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      ck_q    <= 1'b0;
      snl_q   <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= 64'h0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ck_q    <= ck_d;
      snl_q   <= snl_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign chipid_clk      = ck_q;
  assign chipid_shiftnld = snl_q;
  assign aso_out0_valid  = valid_q;
  assign aso_out0_data   = data_q;

endmodule

// File: tb/tb_chip_id_shift_reader.sv
// Bench for chip_id_shift_reader: three instances (CLK_DIV 2/4/8) each driven by a behavioural hard chip ID block.
module tb_chip_id_shift_reader;

  localparam logic [63:0] ID_A = 64'hA5A5_0123_4567_89AB;
  localparam logic [63:0] ID_B = 64'hFFFF_0000_FFFF_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic        rescan = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] model_id = ID_A;
  int          edge_cnt = 0;

  logic        ck [3];
  logic        snl [3];
  logic        vld [3];
  logic        regout [3];
  logic [63:0] dat [3];

  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [63:0] hard_q;
    always @(posedge ck[gi]) begin
      if (!snl[gi]) hard_q <= model_id;
      else          hard_q <= {1'b0, hard_q[63:1]};
    end
    assign regout[gi] = hard_q[0];

    chip_id_shift_reader #(.CLK_DIV(2 << gi)) u_dut (
      .clk             (clk),
      .reset           (reset),
      .chipid_clk      (ck[gi]),
      .chipid_shiftnld (snl[gi]),
      .chipid_regout   (regout[gi]),
      .aso_out0_data   (dat[gi]),
      .aso_out0_valid  (vld[gi]),
`ifdef CHIP_ID_RESCAN_EN
      .rescan          (rescan),
`endif
      .aso_out0_ready  (ready)
    );
  end

  // Per-read observation: chipid_clk rises, rises with shiftnld low, valid rises and stability while valid.
  int          rises [3];
  int          lows [3];
  int          vrs [3];
  int          vedge [3];
  int          stuck [3];
  logic        pck [3];
  logic        pvld [3];
  logic [63:0] held [3];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (reset || clr) begin
        rises[i] <= 0;
        lows[i]  <= 0;
        vrs[i]   <= 0;
        vedge[i] <= 0;
        stuck[i] <= 0;
      end else begin
        if (ck[i] && !pck[i]) begin
          rises[i] <= rises[i] + 1;
          if (!snl[i]) lows[i] <= lows[i] + 1;
        end
        if (vld[i] && !pvld[i]) begin
          vrs[i]   <= vrs[i] + 1;
          vedge[i] <= edge_cnt;
          held[i]  <= dat[i];
        end
        if (pvld[i] && (!vld[i] || dat[i] != held[i] || ck[i])) stuck[i] <= stuck[i] + 1;
      end
      pck[i]  <= ck[i];
      pvld[i] <= vld[i];
    end
  end

  function automatic int ref_latency(input int idx);
    return 64 * (2 << idx);
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[div%0d] got=%0h want=%0h", name, 2 << idx, act, exp);
    end
  endtask

  task automatic release_reset(input logic [63:0] id);
    @(negedge clk);
    reset = 1'b1;
    model_id = id;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    int g = 0;
    while (edge_cnt < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_all_valid();
    int n = 0;
    while (!(vld[0] && vld[1] && vld[2]) && n < 700) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 2, {63'd0, vld[0] && vld[1] && vld[2]}, 64'd1);
  endtask

  task automatic check_read(input logic [63:0] id, input int start_edge);
    for (int i = 0; i < 3; i++) begin
      check("valid_edge", i, vedge[i], start_edge + ref_latency(i));
      check("data", i, dat[i], id);
      check("clk_rises", i, rises[i], 64);
      check("load_rises", i, lows[i], 1);
      check("valid_rises", i, vrs[i], 1);
      check("stable", i, stuck[i], 0);
    end
  endtask

  typedef struct {
    logic [63:0] id_first;
    int          abort_edge;
    logic [63:0] id_final;
    int          exp_edge_div4;
  } read_vec_t;

  read_vec_t vecs [3];

  initial begin
    logic [63:0] rid;
    int          ab;
    int          resc_edge;

    vecs[0] = '{ID_A, 0,   ID_A, 257};
    vecs[1] = '{ID_A, 100, ID_B, 257};
    vecs[2] = '{ID_B, 40,  ID_A, 257};

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_clk", i, ck[i], 0);
      check("rst_snl", i, snl[i], 1);
      check("rst_valid", i, vld[i], 0);
      check("rst_data", i, dat[i], 64'h0);
    end

    for (int v = 0; v < 3; v++) begin
      release_reset(vecs[v].id_first);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check("edge1_snl", i, snl[i], 0);
        check("edge1_clk", i, ck[i], 0);
      end
      if (vecs[v].abort_edge > 0) begin
        wait_edge(vecs[v].abort_edge);
        for (int i = 0; i < 3; i++) check("pre_abort_valid", i, vrs[i], 0);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
          check("abort_valid", i, vld[i], 0);
          check("abort_clk", i, ck[i], 0);
          check("abort_snl", i, snl[i], 1);
        end
        release_reset(vecs[v].id_final);
      end
      wait_all_valid();
      check("table_edge_div4", 1, vedge[1], vecs[v].exp_edge_div4);
      check_read(vecs[v].id_final, 1);
    end

    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      ready = 1'($urandom_range(0, 1));
    end
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ready_stable", i, stuck[i], 0);
      check("ready_valid", i, vld[i], 1);
      check("ready_clk", i, ck[i], 0);
      check("ready_data", i, dat[i], vecs[2].id_final);
    end

    for (int r = 0; r < 3; r++) begin
      rid = {$urandom, $urandom};
      ab  = $urandom_range(0, 1) ? int'($urandom_range(10, 120)) : 0;
      release_reset({$urandom, $urandom});
      if (ab > 0) begin
        wait_edge(ab);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check("rand_abort_valid", i, vld[i], 0);
      end
      release_reset(rid);
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        ready = 1'($urandom_range(0, 1));
      end
      wait_all_valid();
      check_read(rid, 1);
    end

`ifdef CHIP_ID_RESCAN_EN
    release_reset(ID_A);
    wait_edge(59);
    rescan = 1'b1;
    @(negedge clk);
    rescan = 1'b0;
    wait_all_valid();
    check_read(ID_A, 1);

    model_id = 64'h1;
    repeat (5) @(negedge clk);
    rescan = 1'b1;
    clr = 1'b1;
    resc_edge = edge_cnt + 1;
    @(negedge clk);
    rescan = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) check("rescan_drop", i, vld[i], 0);
    wait_all_valid();
    check_read(64'h1, resc_edge);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
